// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble).
// One shift-and-add-3 iteration per clock over all BCD nibbles in parallel,
// with a start/busy/done handshake. Results are held until the next done pulse.
module bin_a_bcd_secuencial #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    localparam int NDIG_W = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [NDIG_W-1:0]     ndig
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int BCD_W = 4 * DIGITS;
    localparam longint unsigned MAX_BIN =
        (BIN_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << BIN_W) - 64'd1);

    // True when DIGITS decimal digits can represent every BIN_W-bit value.
    function automatic bit digits_cover_range();
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (p <= MAX_BIN) begin
                p = p * 64'd10;
            end
        end
        return p > MAX_BIN;
    endfunction

    generate
        if (BIN_W < 4 || !digits_cover_range()) begin : g_bad_params
            $error("bin_a_bcd_secuencial: need BIN_W>=4 and 10**DIGITS > 2**BIN_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_reg,   state_next;
    logic [BCD_W-1:0]    scratch_reg, scratch_next;
    logic [BIN_W-1:0]    bin_reg,     bin_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic [BCD_W-1:0]    bcd_reg,     bcd_next;
    logic [NDIG_W-1:0]   ndig_reg,    ndig_next;

    // One iteration's worth of datapath, computed from the current scratch/bin.
    logic [BCD_W-1:0]    corr;
    logic [BCD_W-1:0]    step_scratch;
    logic [BIN_W-1:0]    step_bin;
    logic [NDIG_W-1:0]   step_ndig;

    // Add-3 correction on every nibble that is 5 or more; a corrected nibble
    // tops out at 12, so it never carries into its neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign corr[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                   ? scratch_reg[4*gi +: 4] + 4'd3
                                   : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // Shift the corrected scratch and the remaining binary bits left as one word.
    always_comb begin
        {step_scratch, step_bin} = {corr, bin_reg} << 1;
    end

    // Count of significant digits in the post-step scratch (minimum one).
    always_comb begin
        step_ndig = NDIG_W'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (step_scratch[4*i +: 4] != 4'd0) begin
                step_ndig = NDIG_W'(i + 1);
            end
        end
    end

    // Next-state and datapath control. The final iteration writes the result
    // registers directly so they are already valid during the done cycle.
    always_comb begin
        state_next   = state_reg;
        scratch_next = scratch_reg;
        bin_next     = bin_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        ndig_next    = ndig_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_CONV;
                    bin_next     = bin_in;
                    scratch_next = '0;
                    cnt_next     = CNT_W'(BIN_W - 1);
                end
            end
            S_CONV: begin
                scratch_next = step_scratch;
                bin_next     = step_bin;
                cnt_next     = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                    bcd_next   = step_scratch;
                    ndig_next  = step_ndig;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            scratch_reg <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            ndig_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            scratch_reg <= scratch_next;
            bin_reg     <= bin_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            ndig_reg    <= ndig_next;
        end
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign bcd_out = bcd_reg;
    assign ndig    = ndig_reg;

endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// Directed testbench for bin_a_bcd_secuencial: a 16-bit/5-digit instance for
// handshake, latency, throughput and reset behaviour, and an 8-bit/3-digit
// instance swept exhaustively against a divide-by-ten reference.
module tb_bin_a_bcd_secuencial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start_a;
    logic [15:0] bin_a;
    logic        busy_a, done_a;
    logic [19:0] bcd_a;
    logic [2:0]  ndig_a;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b, done_b;
    logic [11:0] bcd_b;
    logic [1:0]  ndig_b;

    bin_a_bcd_secuencial #(.BIN_W(16), .DIGITS(5)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_a),
        .bin_in  (bin_a),
        .busy    (busy_a),
        .done    (done_a),
        .bcd_out (bcd_a),
        .ndig    (ndig_a)
    );

    bin_a_bcd_secuencial #(.BIN_W(8), .DIGITS(3)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .bin_in  (bin_b),
        .busy    (busy_b),
        .done    (done_b),
        .bcd_out (bcd_b),
        .ndig    (ndig_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division.
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ref_ndig(input int v);
        int n;
        int x;
        n = 1;
        x = v / 10;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        return n;
    endfunction

    // One conversion on the 16-bit instance with full handshake checks.
    task automatic run_a(input logic [15:0] v, input logic [19:0] eb, input logic [2:0] en);
        int cyc;
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = v;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = ~v;
        cyc     = 1;
        chk("a_busy_rise", 32'(busy_a), 32'd1);
        while (!done_a && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_latency", 32'(cyc), 32'd17);
        chk("a_bcd", 32'(bcd_a), 32'(eb));
        chk("a_ndig", 32'(ndig_a), 32'(en));
        $display("conv a: bin=%0d bcd=%05h ndig=%0d done_cycle=%0d", v, bcd_a, ndig_a, cyc);
        @(negedge clk);
        chk("a_done_pulse", 32'(done_a), 32'd0);
        chk("a_busy_fall", 32'(busy_a), 32'd0);
        chk("a_hold", 32'(bcd_a), 32'(eb));
    endtask

    // One conversion on the 8-bit instance, checked against the reference.
    task automatic run_b(input int v);
        int cyc;
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = 8'(v);
        @(negedge clk);
        start_b = 1'b0;
        bin_b   = 8'(~v);
        cyc     = 1;
        while (!done_b && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_latency", 32'(cyc), 32'd9);
        chk("b_bcd", 32'(bcd_b), ref_bcd(v) & 32'hFFF);
        chk("b_ndig", 32'(ndig_b), 32'(ref_ndig(v)));
        $display("conv b: bin=%0d bcd=%03h ndig=%0d done_cycle=%0d", v, bcd_b, ndig_b, cyc);
    endtask

    initial begin
        int dones;
        int first;
        int last;
        int idx;
        int c;
        logic [19:0] got;
        logic [15:0] t4_vals [3];
        logic [19:0] t4_bcd  [3];
        logic [2:0]  t4_nd   [3];

        t4_vals = '{16'd10, 16'd99, 16'd100};
        t4_bcd  = '{20'h00010, 20'h00099, 20'h00100};
        t4_nd   = '{3'd2, 3'd2, 3'd3};

        rst_n   = 1'b0;
        start_a = 1'b0;
        bin_a   = '0;
        start_b = 1'b0;
        bin_b   = '0;
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'd0);
        chk("rst_ndig", 32'(ndig_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero, full scale, mid value.
        run_a(16'd0, 20'h00000, 3'd1);
        run_a(16'hFFFF, 20'h65535, 3'd5);
        run_a(16'd1234, 20'h01234, 3'd4);

        // Second start during conversion is ignored; old result held meanwhile.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd4321;
        dones   = 0;
        first   = 0;
        got     = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) start_a = 1'b0;
            if (k == 5) begin
                start_a = 1'b1;
                bin_a   = 16'd9;
            end
            if (k == 6) start_a = 1'b0;
            if (k == 10) chk("t3_hold_prev", 32'(bcd_a), 32'h01234);
            if (done_a) begin
                dones++;
                if (first == 0) begin
                    first = k;
                    got   = bcd_a;
                end
            end
        end
        chk("t3_done_count", 32'(dones), 32'd1);
        chk("t3_done_cycle", 32'(first), 32'd17);
        chk("t3_bcd", 32'(got), 32'h04321);
        $display("conv a: bin=4321 with ignored restart, bcd=%05h dones=%0d", got, dones);

        // Start held high: back-to-back conversions every BIN_W+2 cycles.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = t4_vals[0];
        idx     = 0;
        last    = 0;
        c       = 0;
        while (idx < 3 && c < 100) begin
            @(negedge clk);
            c++;
            if (done_a) begin
                chk("t4_bcd", 32'(bcd_a), 32'(t4_bcd[idx]));
                chk("t4_ndig", 32'(ndig_a), 32'(t4_nd[idx]));
                chk("t4_period", 32'(c - last), (idx == 0) ? 32'd17 : 32'd18);
                $display("conv a: back-to-back bin=%0d bcd=%05h at cycle %0d", t4_vals[idx], bcd_a, c);
                last = c;
                idx++;
                if (idx < 3) bin_a = t4_vals[idx];
                else start_a = 1'b0;
            end
        end
        chk("t4_count", 32'(idx), 32'd3);

        // Asynchronous reset in the middle of a conversion.
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'hFFFF;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("t5_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", 32'(busy_a), 32'd0);
        chk("t5_bcd_rst", 32'(bcd_a), 32'd0);
        chk("t5_ndig_rst", 32'(ndig_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        chk("t5_bcd_after", 32'(bcd_a), 32'd0);
        $display("conv a: reset mid-conversion, dones=%0d bcd=%05h", dones, bcd_a);
        run_a(16'd7, 20'h00007, 3'd1);

        // Exhaustive sweep of the 8-bit instance.
        for (int v = 0; v < 256; v++) begin
            run_b(v);
        end
        chk("b_255_bcd", 32'(bcd_b), 32'h255);
        chk("b_255_ndig", 32'(ndig_b), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
